// File: rtl/riscv_pkg.sv
// Shared types, defaults and width helpers for the memory preload sequencer.
package riscv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IMEM,
        ST_IFILL,
        ST_DMEM,
        ST_RUN
    } state_t;

    localparam int          DEF_INSTR_W  = 32;
    localparam int          DEF_DATA_W   = 64;
    localparam logic [31:0] DEF_NOP_WORD = 32'h0000_0013;

    // A depth-1 memory still needs a 1-bit address port.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/riscv_mem_preloader_if.sv
// Boot-stream input and memory-load outputs of the preload sequencer.
interface riscv_mem_preloader_if #(
    parameter int INSTR_W    = riscv_pkg::DEF_INSTR_W,
    parameter int DATA_W     = riscv_pkg::DEF_DATA_W,
    parameter int IMEM_DEPTH = 16,
    parameter int DMEM_DEPTH = 16
);
    localparam int IAW = riscv_pkg::addr_w(IMEM_DEPTH);
    localparam int ICW = riscv_pkg::cnt_w(IMEM_DEPTH);
    localparam int DAW = riscv_pkg::addr_w(DMEM_DEPTH);
    localparam int DCW = riscv_pkg::cnt_w(DMEM_DEPTH);

    logic               start;
    logic               s_valid;
    logic               s_ready;
    logic [DATA_W-1:0]  s_word;
    logic               s_last;
    logic [INSTR_W-1:0] instruction;
    logic [IAW-1:0]     instr_addr;
    logic               instruction_memory_cycle;
    logic [DATA_W-1:0]  data;
    logic [DAW-1:0]     data_location;
    logic               data_memory_cycle;
    logic               core_run;
    logic               busy;
    logic               err_overflow;
    logic [ICW-1:0]     imem_count;
    logic [DCW-1:0]     dmem_count;

    modport master (
        output start, s_valid, s_word, s_last,
        input  s_ready, instruction, instr_addr, instruction_memory_cycle,
        input  data, data_location, data_memory_cycle,
        input  core_run, busy, err_overflow, imem_count, dmem_count
    );

    modport slave (
        input  start, s_valid, s_word, s_last,
        output s_ready, instruction, instr_addr, instruction_memory_cycle,
        output data, data_location, data_memory_cycle,
        output core_run, busy, err_overflow, imem_count, dmem_count
    );

endinterface

// File: rtl/preload_phase_ctr.sv
// Saturating per-phase write counter; flags full, last free slot and overflow attempts.
module preload_phase_ctr
    import riscv_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int CW    = cnt_w(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_clr,
    input  logic          i_req,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_last_slot,
    output logic          o_ovf
);
    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_count <= '0;
        else if (i_clr)
            r_count <= '0;
        else if (i_req && !o_full)
            r_count <= r_count + CW'(1);
    end

    assign o_count     = r_count;
    assign o_full      = (r_count == CW'(DEPTH));
    assign o_last_slot = (r_count == CW'(DEPTH - 1));
    assign o_ovf       = i_req & o_full;

endmodule

// File: rtl/riscv_mem_preloader.sv
// Loads imem (NOP-padded) then dmem from a valid/ready stream; releases the core once both are loaded.
module riscv_mem_preloader
    import riscv_pkg::*;
#(
    parameter int               INSTR_W    = DEF_INSTR_W,
    parameter int               DATA_W     = DEF_DATA_W,
    parameter int               IMEM_DEPTH = 16,
    parameter int               DMEM_DEPTH = 16,
    parameter bit               FILL_NOP   = 1'b1,
    parameter logic [INSTR_W-1:0] NOP_WORD = INSTR_W'(DEF_NOP_WORD)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    riscv_mem_preloader_if.slave  bus
);
    localparam int IAW = addr_w(IMEM_DEPTH);
    localparam int ICW = cnt_w(IMEM_DEPTH);
    localparam int DAW = addr_w(DMEM_DEPTH);
    localparam int DCW = cnt_w(DMEM_DEPTH);

    state_t             r_state, w_state_n;
    logic               r_s_ready, r_iwe, r_dwe, r_core_run, r_busy, r_err;
    logic [INSTR_W-1:0] r_instruction, w_instr_n;
    logic [IAW-1:0]     r_instr_addr;
    logic [DATA_W-1:0]  r_data, w_data_n;
    logic [DAW-1:0]     r_data_loc;
    logic               w_acc, w_clr, w_iwe_n, w_dwe_n, w_imem_req, w_dmem_req;
    logic [ICW-1:0]     w_imem_count;
    logic [DCW-1:0]     w_dmem_count;
    logic               w_imem_full, w_imem_last_slot, w_imem_ovf;
    logic               w_dmem_full, w_dmem_last_slot, w_dmem_ovf;

    preload_phase_ctr #(.DEPTH(IMEM_DEPTH)) u_imem_ctr (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_clr       (w_clr),
        .i_req       (w_imem_req),
        .o_count     (w_imem_count),
        .o_full      (w_imem_full),
        .o_last_slot (w_imem_last_slot),
        .o_ovf       (w_imem_ovf)
    );

    preload_phase_ctr #(.DEPTH(DMEM_DEPTH)) u_dmem_ctr (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_clr       (w_clr),
        .i_req       (w_dmem_req),
        .o_count     (w_dmem_count),
        .o_full      (w_dmem_full),
        .o_last_slot (w_dmem_last_slot),
        .o_ovf       (w_dmem_ovf)
    );

    assign w_acc = bus.s_valid & r_s_ready;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_state_n;
    end

    always_comb begin
        w_state_n  = r_state;
        w_clr      = 1'b0;
        w_imem_req = 1'b0;
        w_dmem_req = 1'b0;
        w_iwe_n    = 1'b0;
        w_dwe_n    = 1'b0;
        w_instr_n  = r_instruction;
        w_data_n   = r_data;
        unique case (r_state)
            ST_IDLE, ST_RUN: begin
                if (bus.start) begin
                    w_state_n = ST_IMEM;
                    w_clr     = 1'b1;
                end
            end
            ST_IMEM: begin
                if (w_acc) begin
                    w_imem_req = 1'b1;
                    if (!w_imem_full) begin
                        w_iwe_n   = 1'b1;
                        w_instr_n = bus.s_word[INSTR_W-1:0];
                    end
                    // Padding is decided on the count after this word lands.
                    if (bus.s_last)
                        w_state_n = (FILL_NOP && !w_imem_full && !w_imem_last_slot) ? ST_IFILL : ST_DMEM;
                end
            end
            ST_IFILL: begin
                if (!w_imem_full) begin
                    w_imem_req = 1'b1;
                    w_iwe_n    = 1'b1;
                    w_instr_n  = NOP_WORD;
                end
                if (w_imem_full || w_imem_last_slot)
                    w_state_n = ST_DMEM;
            end
            ST_DMEM: begin
                if (w_acc) begin
                    w_dmem_req = 1'b1;
                    if (!w_dmem_full) begin
                        w_dwe_n  = 1'b1;
                        w_data_n = bus.s_word;
                    end
                    if (bus.s_last)
                        w_state_n = ST_RUN;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_s_ready     <= 1'b0;
            r_iwe         <= 1'b0;
            r_dwe         <= 1'b0;
            r_core_run    <= 1'b0;
            r_busy        <= 1'b0;
            r_err         <= 1'b0;
            r_instruction <= '0;
            r_instr_addr  <= '0;
            r_data        <= '0;
            r_data_loc    <= '0;
        end else begin
            r_s_ready     <= (w_state_n == ST_IMEM) || (w_state_n == ST_DMEM);
            r_core_run    <= (w_state_n == ST_RUN);
            r_busy        <= (w_state_n == ST_IMEM) || (w_state_n == ST_IFILL) || (w_state_n == ST_DMEM);
            r_err         <= w_clr ? 1'b0 : (r_err | w_imem_ovf | w_dmem_ovf);
            r_iwe         <= w_iwe_n;
            r_dwe         <= w_dwe_n;
            r_instruction <= w_instr_n;
            r_data        <= w_data_n;
            if (w_iwe_n) r_instr_addr <= w_imem_count[IAW-1:0];
            if (w_dwe_n) r_data_loc   <= w_dmem_count[DAW-1:0];
        end
    end

    assign bus.s_ready                  = r_s_ready;
    assign bus.instruction              = r_instruction;
    assign bus.instr_addr               = r_instr_addr;
    assign bus.instruction_memory_cycle = r_iwe;
    assign bus.data                     = r_data;
    assign bus.data_location            = r_data_loc;
    assign bus.data_memory_cycle        = r_dwe;
    assign bus.core_run                 = r_core_run;
    assign bus.busy                     = r_busy;
    assign bus.err_overflow             = r_err;
    assign bus.imem_count               = w_imem_count;
    assign bus.dmem_count               = w_dmem_count;

endmodule

// File: tb/tb_riscv_mem_preloader.sv
// Scoreboard bench: two preloaders (16/16 and 4/2 deep) checked write-by-write with latency.
module tb_riscv_mem_preloader;

    typedef struct {
        logic [63:0] val;
        int          addr;
        int          cyc;
    } exp_wr_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    exp_wr_t qa_i[$], qa_d[$], qb_i[$], qb_d[$];
    int      m_icnt[2], m_dcnt[2], m_ph[2];
    bit      m_err[2];

    riscv_mem_preloader_if #(.IMEM_DEPTH(16), .DMEM_DEPTH(16)) ifa ();
    riscv_mem_preloader_if #(.IMEM_DEPTH(4),  .DMEM_DEPTH(2))  ifb ();

    riscv_mem_preloader #(.IMEM_DEPTH(16), .DMEM_DEPTH(16)) dut_a (
        .i_clk (clk), .i_reset (rst), .bus (ifa.slave)
    );
    riscv_mem_preloader #(.IMEM_DEPTH(4), .DMEM_DEPTH(2)) dut_b (
        .i_clk (clk), .i_reset (rst), .bus (ifb.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int idep(input int d); return (d == 0) ? 16 : 4; endfunction
    function automatic int ddep(input int d); return (d == 0) ? 16 : 2; endfunction
    function automatic logic rdy(input int d); return (d == 0) ? ifa.s_ready : ifb.s_ready; endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic push(input int d, input int m, input logic [63:0] v, input int a, input int c);
        exp_wr_t e;
        e.val = v; e.addr = a; e.cyc = c;
        if (d == 0) begin
            if (m == 0) qa_i.push_back(e); else qa_d.push_back(e);
        end else begin
            if (m == 0) qb_i.push_back(e); else qb_d.push_back(e);
        end
    endtask

    task automatic check_wr(input string tag, input int d, input int m, input logic stb,
                            input logic [63:0] val, input int addr);
        exp_wr_t e;
        bit      ok = 1'b1;
        if (d == 0 && m == 0) begin if (qa_i.size() == 0) ok = 0; else e = qa_i.pop_front(); end
        else if (d == 0)      begin if (qa_d.size() == 0) ok = 0; else e = qa_d.pop_front(); end
        else if (m == 0)      begin if (qb_i.size() == 0) ok = 0; else e = qb_i.pop_front(); end
        else                  begin if (qb_d.size() == 0) ok = 0; else e = qb_d.pop_front(); end
        if (!ok) chk({tag, "_unexpected_strobe"}, 64'(stb), 64'd0);
        else begin
            chk({tag, "_addr"}, 64'(addr), 64'(e.addr));
            chk({tag, "_val"},  val, e.val);
            chk({tag, "_cyc"},  64'(cyc), 64'(e.cyc));
        end
    endtask

    always @(negedge clk) begin
        if (ifa.instruction_memory_cycle === 1'b1)
            check_wr("a_imem", 0, 0, ifa.instruction_memory_cycle, {32'b0, ifa.instruction}, int'(ifa.instr_addr));
        if (ifa.data_memory_cycle === 1'b1)
            check_wr("a_dmem", 0, 1, ifa.data_memory_cycle, ifa.data, int'(ifa.data_location));
        if (ifb.instruction_memory_cycle === 1'b1)
            check_wr("b_imem", 1, 0, ifb.instruction_memory_cycle, {32'b0, ifb.instruction}, int'(ifb.instr_addr));
        if (ifb.data_memory_cycle === 1'b1)
            check_wr("b_dmem", 1, 1, ifb.data_memory_cycle, ifb.data, int'(ifb.data_location));
    end

    task automatic model_clear(input int d);
        m_icnt[d] = 0; m_dcnt[d] = 0; m_ph[d] = 0; m_err[d] = 1'b0;
    endtask

    // Reference behaviour of one accepted stream word, including NOP padding timing.
    task automatic model_accept(input int d, input logic [63:0] w, input logic l, input int e);
        if (m_ph[d] == 0) begin
            if (m_icnt[d] < idep(d)) begin
                push(d, 0, {32'b0, w[31:0]}, m_icnt[d], e);
                m_icnt[d]++;
            end else m_err[d] = 1'b1;
            if (l) begin
                m_ph[d] = 1;
                for (int k = 0; m_icnt[d] < idep(d); k++) begin
                    push(d, 0, 64'h13, m_icnt[d], e + 1 + k);
                    m_icnt[d]++;
                end
            end
        end else if (m_ph[d] == 1) begin
            if (m_dcnt[d] < ddep(d)) begin
                push(d, 1, w, m_dcnt[d], e);
                m_dcnt[d]++;
            end else m_err[d] = 1'b1;
            if (l) m_ph[d] = 2;
        end
    endtask

    task automatic drive(input int d, input logic v, input logic [63:0] w, input logic l);
        if (d == 0) begin ifa.s_valid = v; ifa.s_word = w; ifa.s_last = l; end
        else        begin ifb.s_valid = v; ifb.s_word = w; ifb.s_last = l; end
    endtask

    task automatic pulse_start(input int d);
        if (d == 0) ifa.start = 1'b1; else ifb.start = 1'b1;
        @(posedge clk); #1;
        if (d == 0) ifa.start = 1'b0; else ifb.start = 1'b0;
    endtask

    task automatic send(input int d, input logic [63:0] w, input logic l);
        int n = 0;
        drive(d, 1'b1, w, l);
        while (rdy(d) !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (rdy(d) !== 1'b1) chk("accept_timeout", 64'(rdy(d)), 64'd1);
        else begin
            @(posedge clk); #1;
            model_accept(d, w, l, cyc);
        end
        drive(d, 1'b0, 64'd0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ifa.start = 1'b0; ifb.start = 1'b0;
        drive(0, 1'b0, 64'd0, 1'b0);
        drive(1, 1'b0, 64'd0, 1'b0);
        model_clear(0); model_clear(1);
        #3;
        chk("rst_ready",   64'(ifa.s_ready), 0);
        chk("rst_run",     64'(ifa.core_run), 0);
        chk("rst_busy",    64'(ifa.busy), 0);
        chk("rst_err",     64'(ifa.err_overflow), 0);
        chk("rst_icnt",    64'(ifa.imem_count), 0);
        chk("rst_b_run",   64'(ifb.core_run), 0);
        @(posedge clk); #1 rst = 1'b0;

        // reset in the middle of an imem load
        pulse_start(0);
        chk("t1_busy",  64'(ifa.busy), 1);
        chk("t1_ready", 64'(ifa.s_ready), 1);
        send(0, 64'h100, 1'b0);
        send(0, 64'h101, 1'b0);
        send(0, 64'h102, 1'b0);
        @(negedge clk);
        chk("t1_icnt_pre", 64'(ifa.imem_count), 3);
        #2 rst = 1'b1;
        #1;
        chk("t1_instr",  64'(ifa.instruction), 0);
        chk("t1_iaddr",  64'(ifa.instr_addr), 0);
        chk("t1_istb",   64'(ifa.instruction_memory_cycle), 0);
        chk("t1_data",   ifa.data, 0);
        chk("t1_dstb",   64'(ifa.data_memory_cycle), 0);
        chk("t1_run",    64'(ifa.core_run), 0);
        chk("t1_busy0",  64'(ifa.busy), 0);
        chk("t1_ready0", 64'(ifa.s_ready), 0);
        chk("t1_icnt",   64'(ifa.imem_count), 0);
        chk("t1_pend",   64'(qa_i.size()), 0);
        model_clear(0);
        @(posedge clk); #1 rst = 1'b0;

        // short program, NOP padded, then three data words
        pulse_start(0);
        send(0, 64'h0050_0093, 1'b0);
        send(0, 64'h0140_0113, 1'b0);
        send(0, 64'h0020_81b3, 1'b1);
        send(0, 64'd45, 1'b0);
        send(0, 64'd20, 1'b0);
        send(0, 64'hFFFF_FFFF_FFFF_FFEC, 1'b1);
        chk("t3_run",   64'(ifa.core_run), 1);
        chk("t3_ready", 64'(ifa.s_ready), 0);
        chk("t3_busy",  64'(ifa.busy), 0);
        @(negedge clk); #1;
        chk("t2_icnt",  64'(ifa.imem_count), 16);
        chk("t3_dcnt",  64'(ifa.dmem_count), 3);
        chk("t3_err",   64'(ifa.err_overflow), 0);
        chk("t3_pend_i", 64'(qa_i.size()), 0);
        chk("t3_pend_d", 64'(qa_d.size()), 0);

        // restart from RUN; start during IMEM must be ignored
        @(posedge clk); #1;
        pulse_start(0);
        model_clear(0);
        chk("t6_run",  64'(ifa.core_run), 0);
        chk("t6_icnt", 64'(ifa.imem_count), 0);
        chk("t6_dcnt", 64'(ifa.dmem_count), 0);
        chk("t6_busy", 64'(ifa.busy), 1);
        send(0, 64'hFFFF_FFFF_0000_1111, 1'b0);
        pulse_start(0);
        chk("t6_start_ignored", 64'(ifa.imem_count), 1);
        send(0, 64'h0000_2222, 1'b1);
        send(0, 64'h77, 1'b1);
        @(negedge clk); #1;
        chk("t6_icnt_end", 64'(ifa.imem_count), 16);
        chk("t6_dcnt_end", 64'(ifa.dmem_count), 1);
        chk("t6_run_end",  64'(ifa.core_run), 1);
        chk("t6_pend",     64'(qa_i.size() + qa_d.size()), 0);

        // valid held across IDLE and IFILL; dmem overflow on the small instance
        drive(1, 1'b1, 64'hABC, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_idle_ready", 64'(ifb.s_ready), 0);
        chk("t5_idle_icnt",  64'(ifb.imem_count), 0);
        pulse_start(1);
        send(1, 64'hABC, 1'b0);
        send(1, 64'hDEF, 1'b0);
        send(1, 64'h123, 1'b1);
        send(1, 64'd11, 1'b0);
        send(1, 64'd22, 1'b0);
        send(1, 64'd33, 1'b1);
        chk("t4_err",  64'(ifb.err_overflow), 1);
        chk("t4_dcnt", 64'(ifb.dmem_count), 2);
        chk("t4_icnt", 64'(ifb.imem_count), 4);
        chk("t4_run",  64'(ifb.core_run), 1);
        @(negedge clk); #1;
        chk("t4_pend", 64'(qb_i.size() + qb_d.size()), 0);

        // imem overflow: full exactly on a non-last word, dropped word carries last
        @(posedge clk); #1;
        pulse_start(1);
        model_clear(1);
        chk("t4b_err_clr", 64'(ifb.err_overflow), 0);
        for (int i = 1; i <= 5; i++) send(1, 64'(32'h1000 + i), (i == 5));
        send(1, 64'd55, 1'b1);
        chk("t4b_err",  64'(ifb.err_overflow), 64'(m_err[1]));
        chk("t4b_icnt", 64'(ifb.imem_count), 4);
        chk("t4b_dcnt", 64'(ifb.dmem_count), 1);
        chk("t4b_run",  64'(ifb.core_run), 1);
        @(negedge clk); #1;
        chk("t4b_pend", 64'(qb_i.size() + qb_d.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
